// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD down-counter timer.
// State encoding, BCD digit width/limits and the load-value clamp helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam int             BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] SEX_MAX = 4'd5;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] val,
                                                  input logic [BCD_W-1:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: counts MAX..0, wraps to MAX on borrow.
// borrow_in means every lower digit is zero, so this digit steps on the next decrement.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = BCD_MAX
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dec_en,
  input  logic             borrow_in,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] value,
  output logic             borrow_out
);

  logic [BCD_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (dec_en && borrow_in) begin
      value_d = (value_q == '0) ? MAX : value_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value      = value_q;
  assign borrow_out = borrow_in & (value_q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down timer with load/start/pause, tick-strobed counting and done pulse.
// Optional periodic mode: define TIMER_AUTORELOAD_EN to reload the preset on reaching zero.
//
//   state   | meaning
//   IDLE    | loaded or reset, waiting for start
//   RUNNING | decrementing one LSB per tick
//   PAUSED  | holding value, ticks ignored
//   EXPIRED | reached zero, holding 0
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter bit SEXAGESIMAL = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    tick,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    done
);

  localparam int W = BCD_W * DIGITS;

  state_e         state_q, state_d;
  logic           done_q, done_d;
  logic           dec_en;
  logic           digit_load;
  logic [W-1:0]   load_clamped;
  logic [W-1:0]   digit_load_val;
  logic [DIGITS:0] borrow;
  logic           count_zero;
  logic           count_is_one;

  assign borrow[0] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam logic [BCD_W-1:0] DMAX = (SEXAGESIMAL && gi == 1) ? SEX_MAX : BCD_MAX;

    assign load_clamped[gi*BCD_W +: BCD_W] = bcd_clamp(load_value[gi*BCD_W +: BCD_W], DMAX);

    bcd_down_digit #(.MAX(DMAX)) u_digit (
      .clock      (clock),
      .reset      (reset),
      .dec_en     (dec_en),
      .borrow_in  (borrow[gi]),
      .load       (digit_load),
      .load_val   (digit_load_val[gi*BCD_W +: BCD_W]),
      .value      (count[gi*BCD_W +: BCD_W]),
      .borrow_out (borrow[gi+1])
    );
  end

  // The borrow chain out of the top digit is exactly "all digits zero".
  assign count_zero   = borrow[DIGITS];
  assign count_is_one = (count == {{(W-1){1'b0}}, 1'b1});

`ifdef TIMER_AUTORELOAD_EN
  logic [W-1:0] preset_q;
  logic         preset_zero;
  logic         reload;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     preset_q <= '0;
    else if (load) preset_q <= load_clamped;
  end

  assign preset_zero    = (preset_q == '0);
  assign reload         = dec_en & count_is_one & ~preset_zero;
  assign digit_load     = load | reload;
  assign digit_load_val = load ? load_clamped : preset_q;
`else
  assign digit_load     = load;
  assign digit_load_val = load_clamped;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    dec_en  = 1'b0;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, EXPIRED: begin
          if (start && !pause && !count_zero) state_d = RUNNING;
        end
        RUNNING: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            dec_en = 1'b1;
            if (count_is_one) begin
              done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
              if (preset_zero) state_d = EXPIRED;
`else
              state_d = EXPIRED;
`endif
            end
          end
        end
        PAUSED: begin
          if (start && !pause) state_d = RUNNING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign running = (state_q == RUNNING);
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench: mm:ss and plain-decimal instances driven in lockstep,
// compared each cycle against an integer-seconds reference model.
module tb_bcd_down_timer;

  logic        clock = 1'b0;
  logic        reset, load, start, pause, tick;
  logic [15:0] load_value;
  logic [15:0] count_s, count_d;
  logic        running_s, running_d, done_s, done_d;

  int errors = 0;
  int checks = 0;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAU = 2, S_EXP = 3;
  int m_val[2];
  int m_pre[2];
  int m_st[2];
  bit m_done[2];

  always #5 clock = ~clock;

  bcd_down_timer #(.DIGITS(4), .SEXAGESIMAL(1'b1)) u_sex (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .tick(tick),
    .count(count_s), .running(running_s), .done(done_s));

  bcd_down_timer #(.DIGITS(4), .SEXAGESIMAL(1'b0)) u_dec (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .tick(tick),
    .count(count_d), .running(running_d), .done(done_d));

  function automatic logic [15:0] clamp(input logic [15:0] b, input bit sex);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      int mx = (sex && i == 1) ? 5 : 9;
      int d  = int'(b[i*4 +: 4]);
      r[i*4 +: 4] = 4'((d > mx) ? mx : d);
    end
    return r;
  endfunction

  function automatic int bcd_to_int(input logic [15:0] b, input bit sex);
    return int'(b[3:0]) + 10 * int'(b[7:4]) + (sex ? 60 : 100) * int'(b[11:8])
         + (sex ? 600 : 1000) * int'(b[15:12]);
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v, input bit sex);
    logic [15:0] b;
    int r1 = sex ? 6 : 10;
    b[3:0]   = 4'(v % 10); v = v / 10;
    b[7:4]   = 4'(v % r1); v = v / r1;
    b[11:8]  = 4'(v % 10); v = v / 10;
    b[15:12] = 4'(v % 10);
    return b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_val[c] = 0; m_pre[c] = 0; m_st[c] = S_IDLE; m_done[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit ld, input logic [15:0] lv, input bit st,
                            input bit pa, input bit tk);
    for (int c = 0; c < 2; c++) begin
      bit sex = (c == 0);
      m_done[c] = 1'b0;
      if (ld) begin
        m_val[c] = bcd_to_int(clamp(lv, sex), sex);
        m_pre[c] = m_val[c];
        m_st[c]  = S_IDLE;
      end else begin
        case (m_st[c])
          S_RUN: begin
            if (pa) m_st[c] = S_PAU;
            else if (tk) begin
              m_val[c] = m_val[c] - 1;
              if (m_val[c] == 0) begin
                m_done[c] = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                if (m_pre[c] != 0) m_val[c] = m_pre[c];
                else m_st[c] = S_EXP;
`else
                m_st[c] = S_EXP;
`endif
              end
            end
          end
          S_PAU: if (st && !pa) m_st[c] = S_RUN;
          default: if (st && !pa && m_val[c] != 0) m_st[c] = S_RUN;
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/count_sex"},   count_s, int_to_bcd(m_val[0], 1'b1));
    chk({tag, "/count_dec"},   count_d, int_to_bcd(m_val[1], 1'b0));
    chk({tag, "/running_sex"}, {15'd0, running_s}, {15'd0, m_st[0] == S_RUN});
    chk({tag, "/running_dec"}, {15'd0, running_d}, {15'd0, m_st[1] == S_RUN});
    chk({tag, "/done_sex"},    {15'd0, done_s}, {15'd0, m_done[0]});
    chk({tag, "/done_dec"},    {15'd0, done_d}, {15'd0, m_done[1]});
  endtask

  task automatic cycle(input string tag, input bit ld, input logic [15:0] lv,
                       input bit st, input bit pa, input bit tk);
    load = ld; load_value = lv; start = st; pause = pa; tick = tk;
    @(posedge clock);
    model_edge(ld, lv, st, pa, tk);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    #10 reset = 1'b0;

    // mm:ss borrow across the sexagesimal digit
    cycle("t1_load", 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    cycle("t1_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle("t1_tick", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t1_lit_count", count_s, 16'h0059);
    chk("t1_lit_running", {15'd0, running_s}, 16'd1);

    // count to terminal zero
    cycle("t2_load", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    cycle("t2_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle("t2_tick1", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_lit_one", count_s, 16'h0001);
    cycle("t2_tick2", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_lit_done", {15'd0, done_s}, 16'd1);
`ifndef TIMER_AUTORELOAD_EN
    chk("t2_lit_zero", count_s, 16'h0000);
    chk("t2_lit_stopped", {15'd0, running_s}, 16'd0);
`endif
    cycle("t2_after", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("t2_lit_done_drop", {15'd0, done_s}, 16'd0);

    // plain decimal borrow, pause holds value
    cycle("t3_load", 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    cycle("t3_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle("t3_tick", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t3_lit_999", count_d, 16'h0999);
    cycle("t3_pause", 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle("t3_ptick", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t3_lit_held", count_d, 16'h0999);
    cycle("t3_both", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    cycle("t3_resume", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle("t3_tick2", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t3_lit_998", count_d, 16'h0998);

    // clamp and start-at-zero
    cycle("t4_load", 1'b1, 16'h00F7, 1'b0, 1'b0, 1'b0);
    chk("t4_lit_sex", count_s, 16'h0057);
    chk("t4_lit_dec", count_d, 16'h0097);
    cycle("t4_zero", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle("t4_start0", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("t4_lit_idle", {15'd0, running_s}, 16'd0);

    // async reset mid-count, then load beats tick
    cycle("t5_load", 1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
    cycle("t5_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle("t5_tick", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t5_lit_five", count_s, 16'h0005);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t5_reset");
    chk("t5_lit_cleared", count_s, 16'h0000);
    #2 reset = 1'b0;
    cycle("t5_load2", 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    cycle("t5_start2", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle("t5_ldtick", 1'b1, 16'h0042, 1'b0, 1'b0, 1'b1);
    chk("t5_lit_loadwins", count_s, 16'h0042);

`ifdef TIMER_AUTORELOAD_EN
    cycle("t6_load", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    cycle("t6_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle("t6_tick1", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t6_lit_1", count_s, 16'h0001);
    cycle("t6_tick2", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t6_lit_reload", count_s, 16'h0002);
    chk("t6_lit_done", {15'd0, done_s}, 16'd1);
    chk("t6_lit_run", {15'd0, running_s}, 16'd1);
    cycle("t6_tick3", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t6_lit_1b", count_s, 16'h0001);
`endif

    // randomized control mix, small presets favoured so expiry is reached often
    for (int n = 0; n < 600; n++) begin
      bit          ld = ($urandom_range(0, 15) == 0);
      logic [15:0] lv = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 16'h0025))
                                                     : 16'($urandom);
      bit          st = ($urandom_range(0, 3) == 0);
      bit          pa = ($urandom_range(0, 7) == 0);
      bit          tk = ($urandom_range(0, 1) == 1);
      cycle("rand", ld, lv, st, pa, tk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
